multi_clock_divider: RTL

MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

---
 rtl/clkdiv_pkg.sv | 18 +
 rtl/clock_divider_channel.sv | 75 +++++++
 rtl/multi_clock_divider.sv | 84 ++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants for the multi-channel clock divider.
// Holds the default divide width/ratio, the channel limit and the width of
// the channel-select field, plus a small range-check helper.
package clkdiv_pkg;

    localparam int DIV_WIDTH_DEFAULT     = 10;
    localparam int DEFAULT_RATIO_DEFAULT = 4;
    localparam int MAX_CHANNELS          = 8;
    localparam int CHAN_IDX_WIDTH        = 3;

    typedef logic [CHAN_IDX_WIDTH-1:0] chanIdx_t;

    // True when a channel index addresses an instantiated channel.
    function automatic logic channelInRange(chanIdx_t idx, int unsigned channels);
        return 32'(idx) < channels;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active/shadow ratio, pending flag and
// output decode. The active ratio only changes when the counter restarts
// at zero (period wrap, disabled, enable rise or sync), so a period is never
// cut short or stretched by a reload.
module clock_divider_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_WIDTH     = DIV_WIDTH_DEFAULT,
    parameter int DEFAULT_RATIO = DEFAULT_RATIO_DEFAULT
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 LoadStrobe,
    input  logic [DIV_WIDTH-1:0] LoadValue,
    input  logic                 SyncStrobe,
    output logic                 Pending,
    output logic                 ClockOut,
    output logic                 Tick
);

    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] ratio;
    logic [DIV_WIDTH-1:0] shadow;
    logic                 pending;
    logic                 running;

    logic [DIV_WIDTH-1:0] lastCount;
    logic [DIV_WIDTH-1:0] halfPoint;
    logic                 atWrap;
    logic                 restart;
    logic                 applyShadow;

    // Period boundary decode; running is the registered enable, so the first
    // enabled cycle shows count 0 and the first period is full length.
    always_comb begin
        lastCount   = ratio - DIV_WIDTH'(1);
        halfPoint   = lastCount >> 1;
        atWrap      = running && (count == lastCount);
        restart     = SyncStrobe || !Enable || !running || atWrap;
        applyShadow = pending && restart;
    end

    // Counter, ratio and shadow state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count   <= '0;
            ratio   <= DIV_WIDTH'(DEFAULT_RATIO);
            shadow  <= DIV_WIDTH'(DEFAULT_RATIO);
            pending <= 1'b0;
            running <= 1'b0;
        end else begin
            running <= Enable;
            count   <= restart ? '0 : count + DIV_WIDTH'(1);
            if (applyShadow) begin
                ratio   <= shadow;
                pending <= 1'b0;
            end
            // A strobe only arrives while pending is clear, so it never
            // collides with applyShadow.
            if (LoadStrobe) begin
                shadow  <= LoadValue;
                pending <= 1'b1;
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        Pending  = pending;
        Tick     = running && (count == lastCount);
        ClockOut = running && (count > halfPoint);
    end

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider.
// CHANNELS independent dividers share one ratio-load port; load decode and
// error reporting live here, per-channel counting in clock_divider_channel.
// Optional macro CLKDIV_SYNC_EN: when defined, Sync restarts every channel
// at count 0 and applies pending ratios; otherwise Sync is ignored.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int DIV_WIDTH     = DIV_WIDTH_DEFAULT,
    parameter int DEFAULT_RATIO = DEFAULT_RATIO_DEFAULT
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [CHANNELS-1:0]       Enable,
    input  logic                      Load,
    input  logic [CHAN_IDX_WIDTH-1:0] LoadChannel,
    input  logic [DIV_WIDTH-1:0]      LoadRatio,
    output logic                      LoadReady,
    output logic                      LoadError,
    input  logic                      Sync,
    output logic [CHANNELS-1:0]       ClockOut,
    output logic [CHANNELS-1:0]       Tick
);

    logic [CHANNELS-1:0]     channelPending;
    logic [CHANNELS-1:0]     loadStrobe;
    logic [MAX_CHANNELS-1:0] pendingAll;
    logic                    loadAccept;
    logic                    syncStrobe;

`ifdef CLKDIV_SYNC_EN
    assign syncStrobe = Sync;
`else
    logic unusedSync;
    assign unusedSync = Sync;
    assign syncStrobe = 1'b0;
`endif

    // Pending flags padded to the full index range so any LoadChannel value
    // can be looked up safely.
    always_comb begin
        pendingAll                 = '0;
        pendingAll[CHANNELS-1:0]   = channelPending;
    end

    // Load acceptance and per-channel write strobes.
    always_comb begin
        LoadReady  = channelInRange(LoadChannel, CHANNELS) && !pendingAll[LoadChannel];
        loadAccept = Load && LoadReady && (LoadRatio != '0);
    end

    // One-cycle error pulse for a rejected load.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            LoadError <= 1'b0;
        end else begin
            LoadError <= Load && !loadAccept;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : gChannel
        // Route the shared load port to the addressed channel only.
        always_comb begin
            loadStrobe[ch] = loadAccept && (LoadChannel == CHAN_IDX_WIDTH'(ch));
        end

        clock_divider_channel #(
            .DIV_WIDTH     (DIV_WIDTH),
            .DEFAULT_RATIO (DEFAULT_RATIO)
        ) uChannel (
            .Clock      (Clock),
            .Reset      (Reset),
            .Enable     (Enable[ch]),
            .LoadStrobe (loadStrobe[ch]),
            .LoadValue  (LoadRatio),
            .SyncStrobe (syncStrobe),
            .Pending    (channelPending[ch]),
            .ClockOut   (ClockOut[ch]),
            .Tick       (Tick[ch])
        );
    end

endmodule
